// File: rtl/dpi_stream_sched.sv
// dpi_stream_sched: sequences a stream-tagged packet byte stream into the regex matcher bank
// (state restore, byte stream, drain, commit). Define DPI_SCHED_PKTLEN_EN to add pkt_len/pkt_cnt.
module dpi_stream_sched #(
    parameter int               NCAT         = 32'd8,
    parameter int               DRAIN_CYCLES = 32'd2,
    parameter logic [NCAT-1:0]  MASK_RST     = {NCAT{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sop,
    input  logic            in_eop,
    input  logic [5:0]      in_sid,
    input  logic            cfg_we,
    input  logic [5:0]      cfg_addr,
    input  logic [NCAT-1:0] cfg_mask,
    input  logic            flush_req,
    output logic [5:0]      m_stream_id,
    output logic            m_load_state,
    output logic            m_new_stream_id,
    output logic [7:0]      m_char,
    output logic            m_char_vld,
    output logic            m_eop,
    output logic [NCAT-1:0] m_enable,
    output logic            pkt_done,
    output logic            busy,
    output logic            proto_err
`ifdef DPI_SCHED_PKTLEN_EN
    ,
    output logic [15:0]     pkt_len,
    output logic [31:0]     pkt_cnt
`endif
);

    localparam int         NSID     = 32'd64;
    localparam logic [3:0] DRAIN_LD = DRAIN_CYCLES[3:0];

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_EOP    = 3'd5
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              flush_pend_r;
    logic              flush_pend_s;
    logic [NSID-1:0]   seen_r;
    logic [NCAT-1:0]   mask_r [0:NSID-1];
    logic [3:0]        drain_cnt_r;
    logic              first_byte_r;
    logic              hs_s;
    logic              sop_take_s;
    logic              flush_go_s;
    logic              drop_s;

    assign flush_pend_s = flush_pend_r | flush_req;

    // Next-state decode and per-cycle event flags
    always_comb begin
        next_state_s = state_r;
        hs_s         = 1'b0;
        sop_take_s   = 1'b0;
        flush_go_s   = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A pending flush is serviced before any new packet may start
                if (flush_pend_s) begin
                    flush_go_s   = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (in_valid && in_sop) begin
                    sop_take_s   = 1'b1;
                    next_state_s = ST_LOAD;
                end else if (in_valid) begin
                    drop_s       = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: next_state_s = ST_WAIT;
            ST_WAIT: next_state_s = ST_STREAM;
            ST_STREAM: begin
                hs_s = in_valid;
                if (in_valid && in_eop) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == 4'd0) begin
                    next_state_s = ST_EOP;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_EOP:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Flush tracking, seen bitmap, drain counter and protocol error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend_r <= 1'b0;
            seen_r       <= '0;
            drain_cnt_r  <= 4'd0;
            first_byte_r <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            flush_pend_r <= flush_go_s ? 1'b0 : flush_pend_s;
            if (flush_go_s) begin
                seen_r <= '0;
            end else if (sop_take_s) begin
                seen_r[in_sid] <= 1'b1;
            end
            if (state_r == ST_STREAM && next_state_s == ST_DRAIN) begin
                drain_cnt_r <= DRAIN_LD;
            end else if (state_r == ST_DRAIN && drain_cnt_r != 4'd0) begin
                drain_cnt_r <= drain_cnt_r - 4'd1;
            end
            // The sop byte itself is legitimately the first byte handed over in STREAM
            if (sop_take_s) begin
                first_byte_r <= 1'b1;
            end else if (hs_s) begin
                first_byte_r <= 1'b0;
            end
            if (drop_s || (hs_s && in_sop && !first_byte_r)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Per-stream enable mask table
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSID; i++) begin
                mask_r[i] <= MASK_RST;
            end
        end else if (cfg_we) begin
            mask_r[cfg_addr] <= cfg_mask;
        end
    end

    // Registered matcher-side controls, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready        <= 1'b0;
            m_stream_id     <= 6'd0;
            m_load_state    <= 1'b0;
            m_new_stream_id <= 1'b0;
            m_char          <= 8'd0;
            m_char_vld      <= 1'b0;
            m_eop           <= 1'b0;
            m_enable        <= '0;
            pkt_done        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            in_ready        <= (next_state_s == ST_STREAM);
            m_load_state    <= (next_state_s == ST_LOAD);
            m_new_stream_id <= sop_take_s & ~seen_r[in_sid];
            m_char_vld      <= hs_s;
            m_eop           <= (next_state_s == ST_EOP);
            pkt_done        <= (next_state_s == ST_EOP);
            busy            <= (next_state_s != ST_IDLE);
            if (sop_take_s) begin
                m_stream_id <= in_sid;
                m_enable    <= mask_r[in_sid];
            end
            if (hs_s) begin
                m_char <= in_data;
            end
        end
    end

`ifdef DPI_SCHED_PKTLEN_EN
    // Packet length and packet count statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_len <= 16'd0;
            pkt_cnt <= 32'd0;
        end else begin
            if (sop_take_s) begin
                pkt_len <= 16'd0;
            end else if (hs_s) begin
                pkt_len <= pkt_len + 16'd1;
            end
            if (next_state_s == ST_EOP) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
